// File: rtl/life_pkg.sv
// Shared definitions for the sequential Game of Life board: FSM states,
// neighbour ordering into the cell rule, and the generation counter width.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int NB_NW = 0;
    localparam int NB_N  = 1;
    localparam int NB_NE = 2;
    localparam int NB_W  = 3;
    localparam int NB_E  = 4;
    localparam int NB_SW = 5;
    localparam int NB_S  = 6;
    localparam int NB_SE = 7;

    localparam int GEN_W = 16;

endpackage

// File: rtl/gameoflife.sv
// Combinational Conway cell rule: a cell is alive next generation on
// exactly three live neighbours, or on two if it is alive now.
module gameoflife (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    input  logic i5,
    input  logic i6,
    input  logic i7,
    input  logic mid,
    output logic alive
);

    logic [3:0] count;

    always_comb begin
        count = 4'(i0) + 4'(i1) + 4'(i2) + 4'(i3)
              + 4'(i4) + 4'(i5) + 4'(i6) + 4'(i7);
        alive = (count == 4'd3) || ((count == 4'd2) && mid);
    end

endmodule

// File: rtl/life_board_seq.sv
// Sequential Game of Life engine: scans one cell per cycle into a scratch
// board, then commits it. Define LIFE_TORUS_EN for a wrap-around board.
module life_board_seq
    import life_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      load_en,
    input  logic [$clog2(WIDTH)-1:0]  load_x,
    input  logic [$clog2(HEIGHT)-1:0] load_y,
    input  logic                      load_val,
    output logic                      busy,
    output logic                      done,
    output logic [GEN_W-1:0]          gen_count,
    output logic [WIDTH*HEIGHT-1:0]   board
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    state_t                  state;
    logic [XW-1:0]           scan_x;
    logic [YW-1:0]           scan_y;
    logic [WIDTH*HEIGHT-1:0] cur;
    logic [WIDTH*HEIGHT-1:0] nxt;

    logic [7:0] nbrs;
    logic       mid;
    logic       cell_next;
    int         cell_idx;
    int         load_idx;
    logic       load_ok;
    logic       last_x;
    logic       last_y;

    assign board  = cur;
    assign busy   = (state != IDLE);
    assign last_x = (scan_x == XW'(WIDTH - 1));
    assign last_y = (scan_y == YW'(HEIGHT - 1));

    // Load coordinates may exceed the board when WIDTH/HEIGHT are not powers of two.
    assign load_ok  = load_en && (int'(load_x) < WIDTH) && (int'(load_y) < HEIGHT);
    assign load_idx = int'(load_y) * WIDTH + int'(load_x);

    always_comb begin
        int dx;
        int dy;
        int nx;
        int ny;
        dx       = 0;
        dy       = 0;
        nx       = 0;
        ny       = 0;
        nbrs     = '0;
        cell_idx = int'(scan_y) * WIDTH + int'(scan_x);
        mid      = cur[cell_idx];
        for (int k = 0; k < 8; k++) begin
            case (k)
                NB_NW:   begin dx = -1; dy = -1; end
                NB_N:    begin dx =  0; dy = -1; end
                NB_NE:   begin dx =  1; dy = -1; end
                NB_W:    begin dx = -1; dy =  0; end
                NB_E:    begin dx =  1; dy =  0; end
                NB_SW:   begin dx = -1; dy =  1; end
                NB_S:    begin dx =  0; dy =  1; end
                default: begin dx =  1; dy =  1; end
            endcase
            nx = int'(scan_x) + dx;
            ny = int'(scan_y) + dy;
`ifdef LIFE_TORUS_EN
            nx = (nx + WIDTH) % WIDTH;
            ny = (ny + HEIGHT) % HEIGHT;
            nbrs[k] = cur[ny * WIDTH + nx];
`else
            if (nx >= 0 && nx < WIDTH && ny >= 0 && ny < HEIGHT) begin
                nbrs[k] = cur[ny * WIDTH + nx];
            end
`endif
        end
    end

    gameoflife u_rule (
        .i0    (nbrs[NB_NW]),
        .i1    (nbrs[NB_N]),
        .i2    (nbrs[NB_NE]),
        .i3    (nbrs[NB_W]),
        .i4    (nbrs[NB_E]),
        .i5    (nbrs[NB_SW]),
        .i6    (nbrs[NB_S]),
        .i7    (nbrs[NB_SE]),
        .mid   (mid),
        .alive (cell_next)
    );

    // cur is only written in IDLE (loads) and COMMIT, so every cell of a
    // generation sees the same old board.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            nxt       <= '0;
            gen_count <= '0;
            done      <= 1'b0;
            scan_x    <= '0;
            scan_y    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        cur[load_idx] <= load_val;
                    end
                    if (start) begin
                        state  <= SCAN;
                        scan_x <= '0;
                        scan_y <= '0;
                    end
                end
                SCAN: begin
                    nxt[cell_idx] <= cell_next;
                    if (last_x) begin
                        scan_x <= '0;
                        if (last_y) begin
                            state <= COMMIT;
                        end else begin
                            scan_y <= scan_y + YW'(1);
                        end
                    end else begin
                        scan_x <= scan_x + XW'(1);
                    end
                end
                COMMIT: begin
                    cur       <= nxt;
                    gen_count <= gen_count + GEN_W'(1);
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/life_board_seq.md
LIFE_BOARD_SEQ -- requirements
Module: life_board_seq

Interface
REQ-001 Parameter: WIDTH, 8, board columns (3..32).
REQ-002 Parameter: HEIGHT, 8, board rows (3..32).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one generation step; sampled only in IDLE.
REQ-006 load_en  input  1  write one cell of the current board; honoured only in IDLE.
REQ-007 load_x  input  $clog2(WIDTH)  column of load write.
REQ-008 load_y  input  $clog2(HEIGHT)  row of load write.
REQ-009 load_val  input  1  value written (1 = alive).
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  registered one-cycle pulse after a generation commits.
REQ-012 gen_count  output  16  generations committed since reset; wraps 0xFFFF -> 0x0000.
REQ-013 board  output  WIDTH*HEIGHT  current board; bit index y*WIDTH+x.

Function
REQ-014 The block SHALL hold two board registers: cur (drives board) and nxt (scratch).
REQ-015 The FSM SHALL have states IDLE, SCAN, and COMMIT.
REQ-016 In IDLE, with start high, the block SHALL go to SCAN with scan position (x, y) = (0, 0).
REQ-017 In SCAN, each cycle SHALL evaluate exactly one cell, row-major with x fastest, writing the cell-rule result into nxt[y][x].
REQ-018 Neighbour order into the cell rule SHALL be i0=NW, i1=N, i2=NE, i3=W, i4=E, i5=SW, i6=S, i7=SE; mid = cur[y][x].
REQ-019 Cell rule: alive next iff neighbour count = 3, or count = 2 and mid = 1.
REQ-020 After the edge evaluating (WIDTH-1, HEIGHT-1), the block SHALL enter COMMIT.
REQ-021 At the COMMIT edge, the block SHALL copy nxt to cur, increment gen_count, set done high for exactly one cycle, and return to IDLE.
REQ-022 Latency: with start sampled at edge 0, board and gen_count SHALL update at edge WIDTH*HEIGHT+1; done SHALL be high in the following cycle, with busy low in that same cycle.
REQ-023 cur SHALL remain unchanged during SCAN; all cells of a generation SHALL read the same old board.
REQ-024 start and load_en SHALL be ignored while busy.
REQ-025 load_en and start in the same IDLE cycle: the load SHALL be applied at that edge and start accepted; the scan SHALL see the loaded value.
REQ-026 A load with load_x >= WIDTH or load_y >= HEIGHT SHALL be ignored.
REQ-027 start held high continuously SHALL yield back-to-back generations, each needing one IDLE cycle to be re-sampled.

Reset
REQ-028 rst SHALL clear cur, nxt, gen_count, done, and the scan position, and force IDLE.
REQ-029 rst asserted mid-SCAN or in COMMIT SHALL abort the step with no commit, no done pulse, and no gen_count change beyond the clear.

Configuration
REQ-030 With LIFE_TORUS_EN defined, neighbour coordinates SHALL wrap modulo WIDTH/HEIGHT (toroidal board).
REQ-031 Without LIFE_TORUS_EN, off-board neighbours SHALL read as 0 (dead border).

Structure
REQ-032 A shared package life_pkg SHALL hold the FSM state enum (IDLE, SCAN, COMMIT), the neighbour-index constants (NW..SE), and GEN_W=16.
REQ-033 The block SHALL instantiate exactly one gameoflife sub-module as the combinational cell rule; neighbour selection muxing is local to life_board_seq.

Verification
REQ-034 Blinker: 8x8, load (3,2),(3,3),(3,4), start -> board has (2,3),(3,3),(4,3) alive; gen_count=1; done exactly once, 66 cycles after start.
REQ-035 Block still life: 2x2 at (1,1)..(2,2), 4 generations -> board unchanged; gen_count=4.
REQ-036 Edge: cells (7,3),(7,4),(7,5), one generation -> with LIFE_TORUS_EN, (6,4),(7,4),(0,4) alive; without it, (6,4),(7,4) alive only.
REQ-037 Start pulsed again and load_en asserted mid-SCAN -> no effect; single done; board reflects only the original step.
REQ-038 rst asserted at scan cycle 20 -> board all 0, gen_count=0, busy=0, no done pulse.
REQ-039 Same-cycle load_val=1 at (0,0) plus start on an empty board -> step runs; (0,0) dies (0 neighbours); board all 0; gen_count=1.
